// File: rtl/pc_pkg.sv
// Shared types for the PC sequencer: next-PC select codes, fetch FSM states,
// default reset vector and the target-alignment helper.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_PLUS4  = 3'd0,
    SEL_JALR   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JAL    = 3'd3,
    SEL_MTVEC  = 3'd4,
    SEL_MEPC   = 3'd5
  } pcsel_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential-PC incrementer: PC + 4, modulo 2^32, purely combinational.
module pc_incr (
  input  logic [31:0] pc_in,
  output logic [31:0] pc_plus4
);

  assign pc_plus4 = pc_in + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// PC register, next-PC select and IMEM fetch handshake; 2 cycles/instr with zero-wait memory.
// Fetched word is held until decode takes it; redirects during an outstanding fetch are deferred to the ack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RST,
  input  pcsel_t      PC_SOURCE,
  input  logic        REDIRECT,
  input  logic [31:0] JALR_ADDR,
  input  logic [31:0] BRANCH_ADDR,
  input  logic [31:0] JAL_ADDR,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        STALL,
  input  logic        IR_READY,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        ADDR_MISALIGNED
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         ir_valid_q, ir_valid_d;
  logic [31:0]  pend_q, pend_d;
  logic         squash_q, squash_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  raw_target;
  logic [31:0]  target;

  pc_incr u_pc_incr (
    .pc_in    (pc_q),
    .pc_plus4 (pc_plus4)
  );

  // Reserved select codes fall through to PC+4.
  always_comb begin
    case (PC_SOURCE)
      SEL_JALR:   raw_target = JALR_ADDR;
      SEL_BRANCH: raw_target = BRANCH_ADDR;
      SEL_JAL:    raw_target = JAL_ADDR;
      SEL_MTVEC:  raw_target = MTVEC;
      SEL_MEPC:   raw_target = MEPC;
      default:    raw_target = pc_plus4;
    endcase
  end

  assign target = align_word(raw_target);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pend_d     = pend_q;
    squash_d   = squash_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (REDIRECT) pc_d = target;
      end
      S_REQ: begin
        // The request stays up at the old PC until acked; a redirect only retargets what follows.
        if (IMEM_ACK) begin
          if (REDIRECT) begin
            pc_d     = target;
            squash_d = 1'b0;
          end else if (squash_q) begin
            pc_d     = pend_q;
            squash_d = 1'b0;
          end else begin
            ir_d       = IMEM_RDATA;
            ir_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (REDIRECT) begin
          pend_d   = target;
          squash_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (REDIRECT) begin
          pc_d       = target;
          ir_valid_d = 1'b0;
          state_d    = S_REQ;
        end else if (IR_READY && !STALL) begin
          pc_d       = pc_plus4;
          ir_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pend_q     <= '0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pend_q     <= pend_d;
      squash_q   <= squash_d;
    end
  end

  assign IMEM_REQ        = (state_q == S_REQ);
  assign IMEM_ADDR       = pc_q;
  assign PC              = pc_q;
  assign PC_PLUS4        = pc_plus4;
  assign IR              = ir_q;
  assign IR_VALID        = ir_valid_q;
  assign ADDR_MISALIGNED = REDIRECT && (raw_target[1:0] != 2'b00);

endmodule
